// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment order everywhere is {a,b,c,d,e,f,g} with a as the MSB.
package seg7_pkg;

  // Active-low "all segments dark" pattern.
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Build-time shape of one display instance.
  typedef struct packed {
    int num_digits;
    int refresh_div;
  } seg7_cfg_t;

  // Hex nibble to active-low segment pattern (0 lights a segment).
  function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to seven-segment pattern, adjusted for the board's segment
// polarity. Purely combinational.
module seg7_hex_decode
  import seg7_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_ACTIVE_LOW ? seg7_decode(nibble) : ~seg7_decode(nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller.
// Scans NUM_DIGITS digits, one per REFRESH_DIV-cycle slot. Updates arrive
// via valid/ready into a pending buffer and are copied to the display
// register only at a frame boundary (or while disabled), so one frame never
// mixes old and new digits.
// Optional build macro SEG7_DIMMING_EN adds i_bright[3:0]: each slot is cut
// into 16 sub-phases and the anode is driven only in the first i_bright+1.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_DIV    = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_enable,
  input  logic                    i_blank_lz,
`ifdef SEG7_DIMMING_EN
  input  logic [3:0]              i_bright,
`endif
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame
);

  localparam seg7_cfg_t CFG = '{num_digits: NUM_DIGITS, refresh_div: REFRESH_DIV};
  localparam int PW = $clog2(CFG.refresh_div + 1);
  localparam int IW = (CFG.num_digits > 1) ? $clog2(CFG.num_digits) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CFG.refresh_div - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(CFG.num_digits - 1);
  localparam logic [NUM_DIGITS-1:0] AN_IDLE = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [6:0] SEG_IDLE = SEG_ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;
  localparam logic       DP_IDLE  = SEG_ACTIVE_LOW;

  logic [PW-1:0]                presc;
  logic [IW-1:0]                idx;
  logic [NUM_DIGITS-1:0][3:0]   disp_val, pend_val;
  logic [NUM_DIGITS-1:0]        disp_dp, pend_dp;
  logic                         pend_flag;
  logic                         tick, wrap, accept, commit;
  logic [NUM_DIGITS-1:0]        lz;
  logic                         blank, dim_on;
  logic [6:0]                   dec_seg;
  logic [NUM_DIGITS-1:0]        onehot;
  logic [NUM_DIGITS-1:0]        an_nxt;
  logic [6:0]                   seg_nxt;
  logic                         dp_nxt;

  assign tick    = i_enable && (presc == PRESC_LAST);
  assign wrap    = tick && (idx == IDX_LAST);
  assign accept  = i_valid && !pend_flag;
  // A disabled display has no frames to tear, so a pending update lands at once.
  assign commit  = pend_flag && (wrap || !i_enable);
  assign o_ready = !pend_flag;

  // Slot prescaler and digit index; both parked at 0 while disabled so
  // re-enabling restarts the scan at digit 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc <= '0;
      idx   <= '0;
    end else if (!i_enable) begin
      presc <= '0;
      idx   <= '0;
    end else if (tick) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Pending buffer fills on handshake; display register loads on commit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
      disp_val  <= '0;
      disp_dp   <= '0;
    end else begin
      if (accept) begin
        pend_val  <= i_value;
        pend_dp   <= i_dp;
        pend_flag <= 1'b1;
      end
      if (commit) begin
        disp_val  <= pend_val;
        disp_dp   <= pend_dp;
        pend_flag <= 1'b0;
      end
    end
  end

  // lz[k]: every nibble and dp bit from digit k upward is zero.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lz
    assign lz[k] = ~|{disp_val[NUM_DIGITS-1:k], disp_dp[NUM_DIGITS-1:k]};
  end

  assign blank = i_blank_lz && (idx != '0) && lz[idx];

`ifdef SEG7_DIMMING_EN
  localparam int SUB_LEN = REFRESH_DIV / 16;
  assign dim_on = (int'(presc) / SUB_LEN) <= int'(i_bright);
`else
  assign dim_on = 1'b1;
`endif

  seg7_hex_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec (
    .nibble (disp_val[idx]),
    .seg    (dec_seg)
  );

  assign onehot = NUM_DIGITS'(1) << idx;

  // Next-cycle drive for anode, segments and decimal point.
  always_comb begin
    an_nxt  = AN_IDLE;
    seg_nxt = SEG_IDLE;
    dp_nxt  = DP_IDLE;
    if (i_enable) begin
      seg_nxt = dec_seg;
      dp_nxt  = SEG_ACTIVE_LOW ? ~disp_dp[idx] : disp_dp[idx];
      if (!blank && dim_on) an_nxt = AN_ACTIVE_LOW ? ~onehot : onehot;
    end
  end

  // Registered pin drive; reset darkens the display without waiting for a clock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_an    <= AN_IDLE;
      o_seg   <= SEG_IDLE;
      o_dp    <= DP_IDLE;
      o_frame <= 1'b0;
    end else begin
      o_an    <= an_nxt;
      o_seg   <= seg_nxt;
      o_dp    <= dp_nxt;
      o_frame <= wrap;
    end
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Parametrised multiplexed seven-segment display controller for the SweRVolf board tops. It scans NUM_DIGITS common-anode digits from a hex value, with a programmable refresh prescaler, per-digit decimal points and leading-zero blanking. New values are accepted through a valid/ready handshake and take effect only at a frame boundary, so a frame never mixes old and new digits. It runs in the clk_core domain and is fed from GPIO or performance counters.

Parameters:
NUM_DIGITS, 8, number of digits scanned (1..16)
REFRESH_DIV, 100000, clk cycles per digit slot (>=1)
SEG_ACTIVE_LOW, 1, 1: o_seg and o_dp are driven low to light a segment
AN_ACTIVE_LOW, 1, 1: the o_an bit is driven low to select a digit

Ports:
clk  in  1  core clock
rstn  in  1  asynchronous active-low reset
i_value  in  4*NUM_DIGITS  hex nibbles; nibble k is shown on digit k
i_dp  in  NUM_DIGITS  decimal point per digit; bit k drives digit k
i_valid  in  1  update request for i_value and i_dp
o_ready  out  1  update can be accepted this cycle
i_enable  in  1  display enable
i_blank_lz  in  1  leading-zero suppression enable
o_an  out  NUM_DIGITS  one-hot digit select
o_seg  out  7  segments {a,b,c,d,e,f,g}, with a as the MSB
o_dp  out  1  decimal point
o_frame  out  1  one-cycle pulse at every frame start

Behaviour:
- Clocking and reset: one clock (clk). Reset rstn is asynchronous, active-low.
- Reset values: prescaler=0, digit index=0, display and pending registers=0, pending flag=0. Outputs: o_ready=1, o_frame=0, o_an all inactive, o_seg all off, o_dp off.
- Prescaler: counts 0..REFRESH_DIV-1. Slot tick fires in the cycle it equals REFRESH_DIV-1, then it wraps to 0. With REFRESH_DIV=1 the tick fires every cycle. Counter width is $clog2(REFRESH_DIV+1).
- Digit index: increments on each tick and wraps from NUM_DIGITS-1 to 0. The wrap is a frame boundary and o_frame pulses in the cycle after the wrap tick.
- Output pipeline: o_an, o_seg and o_dp are registered from the index and display register, one cycle of latency. The first active cycle after reset release shows digit 0.
- Handshake:
  - An update is accepted when i_valid && o_ready; i_value and i_dp are captured into the pending register and the pending flag is set.
  - o_ready is the inverse of the pending flag.
  - i_valid while o_ready=0 is ignored; the pending register is unchanged.
- Commit: on a frame-boundary tick with the pending flag already set, pending is copied to the display register and the flag clears. o_ready=1 from the next cycle.
  - An acceptance in the same cycle as the boundary tick commits at the following boundary.
- Leading-zero blanking: when i_blank_lz=1, digit k (k>=1) is dark (anode inactive) if nibbles k..NUM_DIGITS-1 are all 0 and dp bits k..NUM_DIGITS-1 are all 0. Digit 0 is never blanked.
- Hex decode, active-low form ({a..g}, a MSB):
  0:0000001 1:1001111 2:0010010 3:0000110 4:1001100 5:0100100 6:0100000 7:0001111
  8:0000000 9:0000100 A:0001000 b:1100000 C:0110001 d:1000010 E:0110000 F:0111000
  - With SEG_ACTIVE_LOW=0 the decode is inverted. o_dp is active-high before the same polarity inversion.
- i_enable=0:
  - Prescaler and index are held at 0; o_an all inactive, o_seg and o_dp off, no o_frame.
  - A pending update commits on any disabled cycle.
  - When i_enable rises, scanning restarts at digit 0.
- Reset mid-operation: all state and outputs return to reset values immediately. A pending update is lost.

Optional Feature:
SEG7_DIMMING_EN:
- Enabled: adds port i_bright[3:0]. Each slot is split into 16 equal sub-phases. The anode is active only in sub-phases < i_bright+1, so i_bright=15 is full brightness. REFRESH_DIV must be a multiple of 16.
- Disabled: no port, and the anode is active for the whole slot.

Decomposition:
- Package seg7_pkg holds:
  - the hex-to-segment constant table as a function seg7_decode(nibble) returning the active-low 7-bit pattern;
  - SEG_OFF=7'b1111111;
  - a seg7_cfg_t typedef for digit count and refresh values.
- One natural combinational sub-module, seg7_hex_decode: nibble in, polarity-adjusted segments out. The scan controller instantiates it once on the muxed nibble.

Test Plan:
- Reset, then release with NUM_DIGITS=8, REFRESH_DIV=4, enable=1 -> o_an=8'hFE and o_seg=7'b0000001 one cycle after release. o_an walks FD, FB, ... every 4 cycles. o_frame pulses once every 32 cycles.
- Load 32'h89ABCDEF with dp=8'h01 mid-frame -> no change until the next o_frame. Then digit0 seg=0111000 with o_dp=0, digit7 seg=0000000. o_ready returns to 1 after the commit.
- Second i_valid while o_ready=0 with value 32'h12345678 -> ignored; the display shows the first value.
- i_blank_lz=1 with value 32'h000000A5 -> digits 2..7 dark, digit1=0001000, digit0=0100100. Value 0 -> only digit0 lit, showing 0000001.
- rstn low during slot 5 -> o_an all 1 and o_seg all 1 in the same cycle, without waiting for a clock edge. After release, scanning restarts at digit 0 showing 0.
- With SEG7_DIMMING_EN, REFRESH_DIV=32, i_bright=3 -> anode active 8 of 32 cycles per slot. i_bright=15 -> 32 of 32.
